// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word per frame and shifts it out as start, data LSB-first, stop.
// Define PARITY_UART_EN to insert an even-parity bit between the data bits and the stop bits.
module fifo_uart_tx #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 16,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_ren,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef PARITY_UART_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
`ifdef PARITY_UART_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q - CNT_W'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
`ifdef PARITY_UART_EN
    parity_d   = parity_q;
`endif
    fifo_ren   = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d    = cnt_q;
        tx_d     = 1'b1;
        fifo_ren = tx_en & ~fifo_empty & reset_n;
        if (fifo_ren) state_d = S_FETCH;
      end
      S_FETCH: begin
        shift_d = fifo_rdata;
`ifdef PARITY_UART_EN
        parity_d = 1'b0;
`endif
        tx_d    = 1'b0;
        cnt_d   = CNT_LOAD;
        idx_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = CNT_LOAD;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
`ifdef PARITY_UART_EN
          parity_d = parity_q ^ shift_q[0];
`endif
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_LOAD;
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
`ifdef PARITY_UART_EN
            // parity_q already folds in the last data bit, so it is the even-parity bit
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
`ifdef PARITY_UART_EN
            parity_d = parity_q ^ shift_q[0];
`endif
          end
        end
      end
`ifdef PARITY_UART_EN
      S_PARITY: begin
        if (cnt_q == '0) begin
          state_d = S_STOP;
          cnt_d   = CNT_LOAD;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        // idx_q counts stop bits here
        if (cnt_q == '0) begin
          if (idx_q == LAST_STOP) begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
            cnt_d      = '0;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = CNT_LOAD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef PARITY_UART_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef PARITY_UART_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the synchronous FIFO: pops words from the FIFO read port and serializes each as an asynchronous serial frame (start, data LSB-first, optional parity, stop) on a single output line. It owns the FIFO read handshake, so the FIFO never sees a read while empty. It sits between the FIFO and the chip pad or serial transceiver.

## Interface
Parameters:
- WIDTH, 8, data bits per frame; must match FIFO word width.
- CLK_DIV, 16, clk cycles per serial bit; legal range ≥ 2.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  single clock for the block; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tx_en  input  1  1 = allowed to start new frames; sampled only in IDLE.
- fifo_empty  input  1  1 = FIFO holds no data.
- fifo_rdata  input  WIDTH  FIFO read data; valid the cycle after fifo_ren is high.
- fifo_ren  output  1  read strobe to FIFO, one cycle per popped word.
- tx  output  1  serial line; idle level 1.
- busy  output  1  1 while a word is fetched or a frame is on the line.
- frame_done  output  1  one-cycle pulse at the end of the last stop bit.

## Operation
- FSM states: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE: fifo_ren = tx_en & ~fifo_empty & reset_n. This is combinational from the registered state. If fifo_ren is high, the next state is FETCH; otherwise the FSM stays in IDLE.
- FETCH: lasts one cycle. At its closing edge, fifo_rdata is loaded into the shift register, the parity register is cleared, tx is registered to 0, and the next state is START.
- START, DATA, PARITY and each stop bit each last exactly CLK_DIV cycles.
  - A down-counter of width $clog2(CLK_DIV) times each bit.
  - A bit index of width $clog2(WIDTH+1) counts data bits.
- DATA: bits are sent LSB first. The shift register shifts right at each bit boundary. Parity accumulates the XOR of the bits sent.
- After bit WIDTH-1, the next state is PARITY if PARITY_UART_EN is defined, else STOP.
- STOP: tx = 1 for STOP_BITS*CLK_DIV cycles. On the final cycle, frame_done pulses and the next state is IDLE.
- busy = 1 in every state except IDLE.
- tx is a registered output with no glitches; it is 1 in IDLE and FETCH.
- tx_en falling mid-frame: the current frame completes normally and no new fetch occurs.
- fifo_empty is ignored outside IDLE.
- Back-to-back frames: IDLE and FETCH add exactly 2 idle-high cycles between the last stop bit and the next start bit.

## Timing
- Reset asserted (async): state=IDLE, tx=1, busy=0, frame_done=0, fifo_ren=0, counters=0, shift register=0.
- Reset mid-frame truncates the frame immediately, with tx forced to 1.
- Latency: let edge T be the edge at which fifo_ren is high in IDLE.
  - busy rises after T.
  - tx falls at T+1.
  - The first data bit appears at T+1+CLK_DIV.
- Frame length on the line: (1 + WIDTH + P + STOP_BITS)*CLK_DIV cycles, where P = 1 with parity and 0 without.
- Minimum word period: frame length + 2 cycles.
- fifo_ren never stays high for more than 1 consecutive cycle.
- fifo_ren is never high while fifo_empty = 1.

## Configuration
- PARITY_UART_EN defined:
  - PARITY state included.
  - Even parity bit sent after the data bits, for CLK_DIV cycles.
  - tx = XOR of all WIDTH data bits.
- Not defined:
  - PARITY state and parity register are not compiled.
  - STOP follows DATA directly.

## Test plan
- Reset/idle: hold reset_n=0 with tx_en=1 and fifo_empty=0 → tx=1, busy=0, fifo_ren=0. Release reset → fifo_ren=1 for exactly one cycle.
- Single frame: WIDTH=8, CLK_DIV=4, STOP_BITS=1, no parity; FIFO holds 0xA5 → tx shows each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles, then frame_done pulses once and busy=0.
- Parity: same stimulus with PARITY_UART_EN defined.
  - 0xA5 → a parity bit of 0 is inserted before stop; frame is 44 cycles.
  - 0x07 → parity bit 1.
- Back-to-back: FIFO holds 0x01, 0x02, 0x03 → exactly three fifo_ren pulses, each start bit exactly 2 cycles after the previous stop bit ends, and data matches in order.
- Gating and empty: tx_en=0 with FIFO non-empty → no fifo_ren, tx=1. Drop tx_en mid-frame → the frame completes and no further read occurs. Empty FIFO with tx_en=1 → no reads.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 → tx=1 and busy=0 asynchronously. After release, the next word is fetched and sent from the start bit.
